// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the colour type used by the pixel generators.
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV   = 4;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL =
      DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
      DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Width of the pixel/line counters; covers totals up to 1024.
  localparam int unsigned CNT_W = 10;

  // {R[3:0], G[3:0], B[3:0]}
  typedef logic [11:0] rgb_t;

  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock into a one-clk pixel enable every CLK_DIV clks.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be at least 2");
  end

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters, registered sync/visibility flags,
// frame pulse and blanked RGB output register.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        video_on,
  output logic        p_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("vga_sync: line or frame total exceeds counter range");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic tick;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap, v_wrap;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q;
  rgb_t             rgb_out_q;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Flags decode the position the counters are about to take, so after the
  // p_tick edge they line up with pix_x/pix_y.
  always_comb begin
    video_on_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    hsync_d    = ~in_window(h_cnt_d, HS_START, HS_END);
    vsync_d    = ~in_window(v_cnt_d, VS_START, VS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      video_on_q   <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      rgb_out_q    <= '0;
    end else begin
      if (tick) begin
        h_cnt_q    <= h_cnt_d;
        v_cnt_q    <= v_cnt_d;
        video_on_q <= video_on_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
      end
      frame_tick_q <= tick && h_wrap && v_wrap;
      rgb_out_q    <= video_on_q ? rgb_t'(rgb_in) : '0;
    end
  end

  assign pix_x      = h_cnt_q;
  assign pix_y      = v_cnt_q;
  assign video_on   = video_on_q;
  assign p_tick     = tick;
  assign frame_tick = frame_tick_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb_out    = rgb_out_q;

endmodule

// File: doc/vga_sync.md
# vga_sync

Generates 640x480@60 Hz VGA timing for the display path. It produces the pixel coordinates and `video_on` consumed by the pixel generators (box/light animation, text overlays), and the `hsync`/`vsync` sent to the connector. It also registers the final RGB with blanking enforced. It sits between the system clock and the VGA pins, upstream of every pixel generator.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz to 25 MHz). Must be at least 2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BACK`, 48: horizontal back porch.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BACK`, 33: vertical back porch.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rgb_in`  in  12  pixel colour from the pixel generator, {R[3:0],G[3:0],B[3:0]}.
- `pix_x`  out  10  current horizontal counter, 0..H_TOTAL-1.
- `pix_y`  out  10  current vertical counter, 0..V_TOTAL-1.
- `video_on`  out  1  high when the current position is visible.
- `p_tick`  out  1  one-clk pixel enable.
- `frame_tick`  out  1  one-clk pulse on the wrap to (0,0).
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `rgb_out`  out  12  registered colour to the DAC pins, forced to 0 when blanked.

## Operation
- Derived values: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `p_tick` is high while `div_cnt == CLK_DIV-1`.
- Horizontal counter `h_cnt` (drives `pix_x`):
  - Advances only in a `p_tick` cycle.
  - At H_TOTAL-1 it wraps to 0 and `v_cnt` advances.
- Vertical counter `v_cnt` (drives `pix_y`):
  - Wraps to 0 when it is at V_TOTAL-1 and `h_cnt` wraps.
  - Both counters wrap in the same cycle at (799,524).
- Registered flags `video_on`, `hsync`, `vsync`:
  - Loaded in each `p_tick` cycle from the decode of the *next* counter values, so they are always aligned with `pix_x`/`pix_y`.
  - `video_on` = (x < H_DISPLAY) and (y < V_DISPLAY).
  - `hsync` = 0 for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), else 1.
  - `vsync` = 0 for y in [490, 491], else 1.
- `frame_tick` is registered, high for exactly one clk: the clk after the `p_tick` cycle in which the counters wrap to (0,0).
- `rgb_out` is updated every clk: `rgb_in` if `video_on`, else 12'h000.

## Timing
- Reset values:
  - `div_cnt`=0, `pix_x`=0, `pix_y`=0.
  - `video_on`=0, `p_tick`=0, `frame_tick`=0.
  - `hsync`=1, `vsync`=1, `rgb_out`=0.
- Pixel 0 of the first frame after reset is blanked (`video_on`=0). It is a documented artefact, not a bug.
- First `p_tick` after reset release: clk index CLK_DIV-1, counting the first non-reset clk as 0.
- `pix_x`/`pix_y` are stable for CLK_DIV clks. Consumers that detect (0,0) see it for CLK_DIV clks per frame.
- `rgb_out` lags `rgb_in` by 1 clk. The pixel generator's own 1-clk register stage adds another clk. The total of 2 clks must stay ≤ CLK_DIV so the colour lands within the correct pixel period.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clks, which is 1,680,000 at the defaults.
- Reset asserted mid-frame: every output returns to its reset value on the next clk edge. The frame restarts at (0,0) after release, with no partial sync pulse stretched.
- CLK_DIV < 2 is an elaboration error.

## Structure
- `vga_timing_pkg` holds:
  - the default timing constants;
  - the derived H_TOTAL/V_TOTAL;
  - the sync start/end positions;
  - the 12-bit colour type, shared with the pixel generators.
- The divider is a natural sub-module: `pixel_tick_div` (parameter CLK_DIV; ports clk, reset, tick).
- Counters, decode and the output registers stay in `vga_sync`.

## Test plan
- Reset release, defaults:
  - First `p_tick` at clk 3.
  - `pix_x` reaches 1 at clk 4.
  - `video_on`=0 during pixel (0,0), then 1 at (1,0).
- One line:
  - `hsync` goes low exactly when `pix_x`=656 and returns high at `pix_x`=752.
  - Low width is 96·4 = 384 clks.
  - Line period is 3200 clks.
- One frame:
  - `vsync` is low for lines 490–491, i.e. 6400 clks.
  - `frame_tick` pulses once every 1,680,000 clks, one clk wide, after (799,524) wraps to (0,0).
- Blanking:
  - Drive `rgb_in`=12'hFFF constantly.
  - `rgb_out`=12'hFFF only while `video_on`=1, 0 at `pix_x`≥640 or `pix_y`≥480.
  - Lag of 1 clk versus `rgb_in`.
- Mid-frame reset:
  - Assert `reset` at (700,300) during an `hsync` low.
  - Next clk: `hsync`=1, `pix_x`=`pix_y`=0, `rgb_out`=0.
  - After release the timing repeats the reset-release scenario.
- CLK_DIV=2: line period is 1600 clks and frame period is 840,000 clks.
